// File: rtl/morse_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : morse_encoder_pkg
//  Purpose  : Shared symbol encodings, FSM states and unit multiples for the
//             Morse transmit path.
//  Revision : 1.0  initial release
// ============================================================================
package morse_encoder_pkg;

  // Two-bit symbol slots inside the 8-bit letter code.
  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b10;
  localparam logic [1:0] SYM_DASH = 2'b11;

  // Length of each keyed/unkeyed interval, in Morse units.
  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;
  localparam int SGAP_UNITS = 1;
  localparam int LGAP_UNITS = 3;
  localparam int WGAP_UNITS = 4;  // letter gap already supplied 3 of the 7

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MARK = 3'd1,
    ST_SGAP = 3'd2,
    ST_LGAP = 3'd3,
    ST_WGAP = 3'd4
  } state_e;

  // Terminal value of the 2-bit unit-within-state counter.
  function automatic logic [1:0] last_unit(input int units);
    return 2'(units - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_encoder_rom.sv
`default_nettype none
// ============================================================================
//  Module   : morse_encoder_rom
//  Purpose  : Combinational ASCII -> Morse code lookup. Folds lowercase to
//             uppercase; valid=0 for anything outside A-Z (space included).
//  Revision : 1.0  initial release
// ============================================================================
module morse_encoder_rom
  import morse_encoder_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] code,
  output logic [2:0] len,
  output logic       valid
);

  logic [7:0] upper;

  // Fold case, then look the letter up; symbols are packed from bit 7 down.
  always_comb begin
    upper = ((ascii >= 8'h61) && (ascii <= 8'h7A)) ? (ascii - 8'h20) : ascii;
    code  = {4{SYM_NONE}};
    len   = 3'd0;
    valid = 1'b1;
    case (upper)
      8'h41: begin code = 8'hB0; len = 3'd2; end  // A .-
      8'h42: begin code = 8'hEA; len = 3'd4; end  // B -...
      8'h43: begin code = 8'hEE; len = 3'd4; end  // C -.-.
      8'h44: begin code = 8'hE8; len = 3'd3; end  // D -..
      8'h45: begin code = 8'h80; len = 3'd1; end  // E .
      8'h46: begin code = 8'hAE; len = 3'd4; end  // F ..-.
      8'h47: begin code = 8'hF8; len = 3'd3; end  // G --.
      8'h48: begin code = 8'hAA; len = 3'd4; end  // H ....
      8'h49: begin code = 8'hA0; len = 3'd2; end  // I ..
      8'h4A: begin code = 8'hBF; len = 3'd4; end  // J .---
      8'h4B: begin code = 8'hEC; len = 3'd3; end  // K -.-
      8'h4C: begin code = 8'hBA; len = 3'd4; end  // L .-..
      8'h4D: begin code = 8'hF0; len = 3'd2; end  // M --
      8'h4E: begin code = 8'hE0; len = 3'd2; end  // N -.
      8'h4F: begin code = 8'hFC; len = 3'd3; end  // O ---
      8'h50: begin code = 8'hBE; len = 3'd4; end  // P .--.
      8'h51: begin code = 8'hFB; len = 3'd4; end  // Q --.-
      8'h52: begin code = 8'hB8; len = 3'd3; end  // R .-.
      8'h53: begin code = 8'hA8; len = 3'd3; end  // S ...
      8'h54: begin code = 8'hC0; len = 3'd1; end  // T -
      8'h55: begin code = 8'hAC; len = 3'd3; end  // U ..-
      8'h56: begin code = 8'hAB; len = 3'd4; end  // V ...-
      8'h57: begin code = 8'hBC; len = 3'd3; end  // W .--
      8'h58: begin code = 8'hEB; len = 3'd4; end  // X -..-
      8'h59: begin code = 8'hEF; len = 3'd4; end  // Y -.--
      8'h5A: begin code = 8'hFA; len = 3'd4; end  // Z --..
      default: valid = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/morse_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : morse_encoder
//  Purpose  : Morse transmitter. Accepts ASCII over valid/ready, keys the
//             LED/speaker with standard Morse timing and exports the letter
//             code for the seven-segment display.
//  Revision : 1.0  initial release
// ============================================================================
module morse_encoder
  import morse_encoder_pkg::*;
#(
  parameter int UNIT_CYCLES = 6_000_000,
  parameter int TONE_BIT    = 17,
  parameter int CNT_W       = 23
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] char,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key,
  output logic       Speaker,
  output logic [7:0] code,
  output logic       err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   unit_cnt_q, unit_cnt_d;
  logic [1:0]         units_q, units_d;
  logic [1:0]         idx_q, idx_d;
  logic [2:0]         len_q, len_d;
  logic [7:0]         code_q, code_d;
  logic [TONE_BIT:0]  tone_q, tone_d;
  logic               key_q, key_d;
  logic               speaker_q, speaker_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;

  logic       accept;
  logic       unit_done;
  logic       state_done;
  logic       more_syms;
  logic       is_dash;
  logic [1:0] term_unit;
  logic [7:0] sym_word;
  logic [7:0] rom_code;
  logic [2:0] rom_len;
  logic       rom_valid;

  morse_encoder_rom u_rom (
    .ascii (char),
    .code  (rom_code),
    .len   (rom_len),
    .valid (rom_valid)
  );

  // Decode the current symbol and when the current state's interval expires.
  always_comb begin
    accept    = char_valid & ready_q;
    unit_done = (unit_cnt_q == CNT_W'(UNIT_CYCLES - 1));
    sym_word  = code_q << {idx_q, 1'b0};
    // Any non-dash slot (including the impossible 01) is keyed as a dot.
    is_dash   = (sym_word[7:6] == SYM_DASH);
    more_syms = (({1'b0, idx_q} + 3'd1) < len_q);
    case (state_q)
      ST_MARK: term_unit = is_dash ? last_unit(DASH_UNITS) : last_unit(DOT_UNITS);
      ST_SGAP: term_unit = last_unit(SGAP_UNITS);
      ST_LGAP: term_unit = last_unit(LGAP_UNITS);
      ST_WGAP: term_unit = last_unit(WGAP_UNITS);
      default: term_unit = 2'd0;
    endcase
    state_done = (state_q != ST_IDLE) && unit_done && (units_q == term_unit);
  end

  // Next-state, timing counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    unit_cnt_d = unit_cnt_q;
    units_d    = units_q;
    idx_d      = idx_q;
    len_d      = len_q;
    code_d     = code_q;
    err_d      = 1'b0;
    tone_d     = tone_q + (TONE_BIT+1)'(1);

    if ((state_q == ST_IDLE) || state_done) begin
      unit_cnt_d = '0;
      units_d    = 2'd0;
    end else if (unit_done) begin
      unit_cnt_d = '0;
      units_d    = units_q + 2'd1;
    end else begin
      unit_cnt_d = unit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (rom_valid) begin
            state_d = ST_MARK;
            code_d  = rom_code;
            len_d   = rom_len;
            idx_d   = 2'd0;
          end else if (char == ASCII_SPACE) begin
            state_d = ST_WGAP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_MARK: if (state_done) state_d = more_syms ? ST_SGAP : ST_LGAP;
      ST_SGAP: if (state_done) begin
        state_d = ST_MARK;
        idx_d   = idx_q + 2'd1;
      end
      ST_LGAP, ST_WGAP: if (state_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    key_d     = (state_d == ST_MARK);
    speaker_d = key_d & tone_d[TONE_BIT];
    // Ready drops on every accepting edge, even a rejected character.
    ready_d   = (state_d == ST_IDLE) && !((state_q == ST_IDLE) && accept);
  end

  // State and output registers; reset silences the key immediately.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      unit_cnt_q <= '0;
      units_q    <= 2'd0;
      idx_q      <= 2'd0;
      len_q      <= 3'd0;
      code_q     <= 8'h00;
      tone_q     <= '0;
      key_q      <= 1'b0;
      speaker_q  <= 1'b0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_cnt_q <= unit_cnt_d;
      units_q    <= units_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      code_q     <= code_d;
      tone_q     <= tone_d;
      key_q      <= key_d;
      speaker_q  <= speaker_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign char_ready = ready_q;
  assign key        = key_q;
  assign Speaker    = speaker_q;
  assign code       = code_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_encoder
//  Purpose  : Self-checking bench for morse_encoder against a dot/dash
//             string model of the alphabet.
//  Revision : 1.0  initial release
// ============================================================================
module tb_morse_encoder;

  localparam int U = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] char = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready, key, Speaker, err;
  logic [7:0] code;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         edges    = 0;
  int         hs       = 0;
  logic [7:0] exp_code = 8'h00;

  string tbl [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                      "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                      "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                      "-.--", "--.."};

  morse_encoder #(.UNIT_CYCLES(U), .TONE_BIT(1), .CNT_W(3)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .char       (char),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .key        (key),
    .Speaker    (Speaker),
    .code       (code),
    .err        (err)
  );

  always #5 Clk = ~Clk;

  // Tone reference: clocks elapsed since reset release.
  always @(posedge Clk or negedge Reset_n)
    if (!Reset_n) edges <= 0; else edges <= edges + 1;

  always @(posedge Clk)
    if (Reset_n && char_valid && char_ready) hs <= hs + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One busy clock: key level, gated tone, ready low, err level.
  task automatic cyc(input bit ek, input bit eerr);
    check("key", key, ek);
    check("speaker", Speaker, ek & edges[1]);
    check("ready_busy", char_ready, 0);
    check("err", err, eerr);
    @(negedge Clk);
  endtask

  // Called at the first negedge after the accepting edge.
  task automatic expect_char(input logic [7:0] c);
    logic [7:0] u;
    string      m;
    u = ((c >= 8'h61) && (c <= 8'h7A)) ? c - 8'h20 : c;
    if ((u >= 8'h41) && (u <= 8'h5A)) begin
      m = tbl[u - 8'h41];
      exp_code = 8'h00;
      for (int j = 0; j < m.len(); j++)
        exp_code[7-2*j -: 2] = (m[j] == "-") ? 2'b11 : 2'b10;
      check("code_letter", code, exp_code);
      for (int j = 0; j < m.len(); j++) begin
        repeat ((m[j] == "-") ? 3*U : U) cyc(1, 0);
        if (j < m.len() - 1) repeat (U) cyc(0, 0);
      end
      repeat (3*U) cyc(0, 0);
    end else if (u == 8'h20) begin
      repeat (4*U) cyc(0, 0);
    end else begin
      cyc(0, 1);
    end
    check("ready_back", char_ready, 1);
    check("key_idle", key, 0);
    check("err_idle", err, 0);
    check("code_hold", code, exp_code);
  endtask

  task automatic send_str(input string s, input bit hold);
    int k;
    for (int i = 0; i < s.len(); i++) begin
      char = s[i];
      char_valid = 1'b1;
      k = 0;
      while (!char_ready && k < 200) begin
        @(negedge Clk);
        k++;
      end
      check("ready_wait", char_ready, 1);
      @(posedge Clk);
      @(negedge Clk);
      if (!hold || i == s.len() - 1) char_valid = 1'b0;
      else char = s[i+1];
      expect_char(s[i]);
    end
  endtask

  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 5))
      0, 1:    return 8'($urandom_range(8'h41, 8'h5A));
      2, 3:    return 8'($urandom_range(8'h61, 8'h7A));
      4:       return 8'h20;
      default: return ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h21, 8'h40))
                                                  : 8'($urandom_range(8'h7B, 8'h7E));
    endcase
  endfunction

  initial begin
    int    hs0;
    string s;

    // Reset values
    repeat (2) @(negedge Clk);
    check("rst_ready", char_ready, 1);
    check("rst_key", key, 0);
    check("rst_speaker", Speaker, 0);
    check("rst_code", code, 8'h00);
    check("rst_err", err, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Asynchronous reset mid-dash of 'T'
    char = "T";
    char_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    char_valid = 1'b0;
    repeat (5) @(negedge Clk);
    check("t_key_on", key, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_key", key, 0);
    check("arst_speaker", Speaker, 0);
    check("arst_ready", char_ready, 1);
    check("arst_code", code, 8'h00);
    exp_code = 8'h00;
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("no_resume_key", key, 0);
      check("no_resume_ready", char_ready, 1);
    end
    check("post_rst_code", code, 8'h00);

    // Directed letters
    send_str("E", 0);
    send_str("a", 0);
    send_str("A", 0);
    send_str("Q", 0);

    // Stream with valid held: exactly three transfers
    hs0 = hs;
    send_str("E E", 1);
    check("handshakes", hs - hs0, 3);

    // Unsupported character
    send_str("5", 0);

    // Randomized strings, alternating held and dropped valid
    for (int r = 0; r < 4; r++) begin
      s = "";
      for (int i = 0; i < 8; i++) begin
        s = {s, "x"};
        s.putc(i, rand_char());
      end
      hs0 = hs;
      send_str(s, r[0]);
      check("rand_handshakes", hs - hs0, 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
